// File: rtl/flg_match_sched.sv
// flg_match_sched: sequencer for the sparse flag-matching datapath.
//
// For each activation/weight flag word pair, walks the set bits of
// (act & wei) lowest first. For every match it emits the absolute
// compressed-buffer addresses of that element on both sides. Base addresses
// carry across words so a whole kernel pass appears as one flat address
// stream.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_start, cfg_num_words     pass start pulse and word-pair count
//   in_valid/in_ready            flag word pair handshake (in_flg_act, in_flg_wei)
//   out_valid/out_ready          match handshake (out_addr_act, out_addr_wei, out_last)
//   busy, done                   pass in progress, one-cycle end-of-pass pulse
//   match_cnt, stall_cnt         accepted matches, backpressure cycles
//
// Optional build macro: FLG_MATCH_SCHED_STAT_EN enables the saturating
// stall_cnt counter. Without it, stall_cnt is tied to zero.
module flg_match_sched #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BASE_WIDTH  = 12,
   parameter int unsigned NWORD_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_start,
   input  logic [NWORD_WIDTH-1:0] cfg_num_words,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_flg_act,
   input  logic [DATA_WIDTH-1:0]  in_flg_wei,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BASE_WIDTH-1:0]  out_addr_act,
   output logic [BASE_WIDTH-1:0]  out_addr_wei,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            match_cnt,
   output logic [15:0]            stall_cnt
);

   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_ISSUE, ST_ADVANCE, ST_DONE} state_t;

   state_t                 state_q, state_d;
   logic [NWORD_WIDTH-1:0] num_words_q, num_words_d;
   logic [NWORD_WIDTH-1:0] word_cnt_q, word_cnt_d;
   logic [DATA_WIDTH-1:0]  act_q, act_d, wei_q, wei_d, pend_q, pend_d;
   logic [BASE_WIDTH-1:0]  base_act_q, base_act_d, base_wei_q, base_wei_d;
   logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [BASE_WIDTH-1:0]  out_addr_act_q, out_addr_act_d, out_addr_wei_q, out_addr_wei_d;
   logic [15:0]            match_cnt_q, match_cnt_d;

   logic [DATA_WIDTH-1:0]  src_act, src_wei, src_pend, lsb, below;
   logic [BASE_WIDTH-1:0]  nxt_addr_act, nxt_addr_wei;
   logic                   nxt_last, last_word, fire;

   // Population count reduced modulo 2^BASE_WIDTH, matching the silent base wrap.
   function automatic logic [BASE_WIDTH-1:0] popcnt(input logic [DATA_WIDTH-1:0] v);
      logic [BASE_WIDTH-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) c = c + BASE_WIDTH'(v[i]);
      return c;
   endfunction

   // Outputs are registered. The match presented next is computed from the incoming
   // word while fetching, or from the pending set with the accepted bit removed while
   // issuing. This gives a valid output on the cycle after accept and one match per cycle.
   always_comb begin
      fire      = out_valid_q & out_ready;
      last_word = (word_cnt_q + NWORD_WIDTH'(1)) == num_words_q;
      if (state_q == ST_FETCH) begin
         src_act  = in_flg_act;
         src_wei  = in_flg_wei;
         src_pend = in_flg_act & in_flg_wei;
      end else begin
         src_act  = act_q;
         src_wei  = wei_q;
         src_pend = pend_q & (pend_q - DATA_WIDTH'(1));
      end
      lsb          = src_pend & (~src_pend + DATA_WIDTH'(1));
      below        = lsb - DATA_WIDTH'(1);
      nxt_addr_act = base_act_q + popcnt(src_act & below);
      nxt_addr_wei = base_wei_q + popcnt(src_wei & below);
      nxt_last     = last_word && ((src_pend & ~lsb) == '0);
   end

   always_comb begin
      state_d        = state_q;
      num_words_d    = num_words_q;
      word_cnt_d     = word_cnt_q;
      act_d          = act_q;
      wei_d          = wei_q;
      pend_d         = pend_q;
      base_act_d     = base_act_q;
      base_wei_d     = base_wei_q;
      out_valid_d    = out_valid_q;
      out_last_d     = out_last_q;
      out_addr_act_d = out_addr_act_q;
      out_addr_wei_d = out_addr_wei_q;
      match_cnt_d    = match_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               num_words_d = cfg_num_words;
               base_act_d  = '0;
               base_wei_d  = '0;
               word_cnt_d  = '0;
               match_cnt_d = '0;
               state_d     = (cfg_num_words == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (in_valid) begin
               act_d  = in_flg_act;
               wei_d  = in_flg_wei;
               pend_d = src_pend;
               if (src_pend == '0) begin
                  state_d = ST_ADVANCE;
               end else begin
                  state_d        = ST_ISSUE;
                  out_valid_d    = 1'b1;
                  out_addr_act_d = nxt_addr_act;
                  out_addr_wei_d = nxt_addr_wei;
                  out_last_d     = nxt_last;
               end
            end
         end
         ST_ISSUE: begin
            if (fire) begin
               pend_d      = src_pend;
               match_cnt_d = match_cnt_q + 16'd1;
               if (src_pend != '0) begin
                  out_addr_act_d = nxt_addr_act;
                  out_addr_wei_d = nxt_addr_wei;
                  out_last_d     = nxt_last;
               end else begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = ST_ADVANCE;
               end
            end
         end
         ST_ADVANCE: begin
            base_act_d = base_act_q + popcnt(act_q);
            base_wei_d = base_wei_q + popcnt(wei_q);
            word_cnt_d = word_cnt_q + NWORD_WIDTH'(1);
            state_d    = last_word ? ST_DONE : ST_FETCH;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         num_words_q    <= '0;
         word_cnt_q     <= '0;
         act_q          <= '0;
         wei_q          <= '0;
         pend_q         <= '0;
         base_act_q     <= '0;
         base_wei_q     <= '0;
         out_valid_q    <= 1'b0;
         out_last_q     <= 1'b0;
         out_addr_act_q <= '0;
         out_addr_wei_q <= '0;
         match_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         num_words_q    <= num_words_d;
         word_cnt_q     <= word_cnt_d;
         act_q          <= act_d;
         wei_q          <= wei_d;
         pend_q         <= pend_d;
         base_act_q     <= base_act_d;
         base_wei_q     <= base_wei_d;
         out_valid_q    <= out_valid_d;
         out_last_q     <= out_last_d;
         out_addr_act_q <= out_addr_act_d;
         out_addr_wei_q <= out_addr_wei_d;
         match_cnt_q    <= match_cnt_d;
      end
   end

`ifdef FLG_MATCH_SCHED_STAT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == ST_IDLE && cfg_start)
         stall_cnt_d = '0;
      else if (out_valid_q && !out_ready && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

   assign in_ready     = (state_q == ST_FETCH);
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign out_valid    = out_valid_q;
   assign out_last     = out_last_q;
   assign out_addr_act = out_addr_act_q;
   assign out_addr_wei = out_addr_wei_q;
   assign match_cnt    = match_cnt_q;

endmodule

// File: tb/tb_flg_match_sched.sv
module tb_flg_match_sched;

   logic        clk, rst_n, cfg_start, in_valid, out_ready;
   logic [15:0] cfg_num_words;
   logic [31:0] in_flg_act, in_flg_wei;

   logic        in_ready, out_valid, out_last, busy, done;
   logic [11:0] out_addr_act, out_addr_wei;
   logic [15:0] match_cnt, stall_cnt;

   logic        in_ready5, out_valid5, out_last5, busy5, done5;
   logic [4:0]  out_addr_act5, out_addr_wei5;
   logic [15:0] match_cnt5, stall_cnt5;

   flg_match_sched #(.DATA_WIDTH(32), .BASE_WIDTH(12), .NWORD_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_words(cfg_num_words),
      .in_valid(in_valid), .in_ready(in_ready), .in_flg_act(in_flg_act), .in_flg_wei(in_flg_wei),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr_act(out_addr_act),
      .out_addr_wei(out_addr_wei), .out_last(out_last), .busy(busy), .done(done),
      .match_cnt(match_cnt), .stall_cnt(stall_cnt));

   // Narrow-base instance sharing all stimulus, used to observe address wrap.
   flg_match_sched #(.DATA_WIDTH(32), .BASE_WIDTH(5), .NWORD_WIDTH(16)) dut5 (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_words(cfg_num_words),
      .in_valid(in_valid), .in_ready(in_ready5), .in_flg_act(in_flg_act), .in_flg_wei(in_flg_wei),
      .out_valid(out_valid5), .out_ready(out_ready), .out_addr_act(out_addr_act5),
      .out_addr_wei(out_addr_wei5), .out_last(out_last5), .busy(busy5), .done(done5),
      .match_cnt(match_cnt5), .stall_cnt(stall_cnt5));

   typedef struct {
      int a;
      int w;
      bit last;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec, n_err;
   int   tb_stall, stall_base;
   int   mbase_a, mbase_w, mword, mnw;
   bit   mon_en, tog, ready_level;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            if (out_valid && !out_ready) tb_stall++;
            chk("valid_w5_agree", {31'd0, out_valid5}, {31'd0, out_valid});
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
               end else begin
                  e = exp_q[0];
                  chk("addr_act", {20'd0, out_addr_act}, e.a & 32'hFFF);
                  chk("addr_wei", {20'd0, out_addr_wei}, e.w & 32'hFFF);
                  chk("last", {31'd0, out_last}, {31'd0, e.last});
                  chk("addr_act_w5", {27'd0, out_addr_act5}, e.a & 32'h1F);
                  chk("addr_wei_w5", {27'd0, out_addr_wei5}, e.w & 32'h1F);
                  if (out_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #1;
         out_ready = tog ? ~out_ready : ready_level;
      end
   endtask

   task automatic push_word(input logic [31:0] a, input logic [31:0] w);
      logic [31:0] p, mask;
      int   hi;
      exp_t e;
      p  = a & w;
      hi = -1;
      for (int i = 0; i < 32; i++) if (p[i]) hi = i;
      for (int i = 0; i < 32; i++) begin
         if (p[i]) begin
            mask   = (32'h1 << i) - 32'h1;
            e.a    = mbase_a + $countones(a & mask);
            e.w    = mbase_w + $countones(w & mask);
            e.last = (mword == mnw - 1) && (i == hi);
            exp_q.push_back(e);
         end
      end
      mbase_a += $countones(a);
      mbase_w += $countones(w);
      mword++;
   endtask

   task automatic start_pass(input int nw);
      mbase_a       = 0;
      mbase_w       = 0;
      mword         = 0;
      mnw           = nw;
      stall_base    = tb_stall;
      cfg_num_words = 16'(nw);
      cfg_start     = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] a, input logic [31:0] w);
      bit ok;
      push_word(a, w);
      in_flg_act = a;
      in_flg_wei = w;
      in_valid   = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("fetch_accept", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int exp_m);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", {31'd0, seen}, 32'd1);
      chk("busy_at_done", {31'd0, busy}, 32'd1);
      chk("match_cnt", {16'd0, match_cnt}, 32'(exp_m));
      chk("match_cnt_w5", {16'd0, match_cnt5}, 32'(exp_m));
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit ok;
      n_vec = 0; n_err = 0; tb_stall = 0; stall_base = 0;
      mbase_a = 0; mbase_w = 0; mword = 0; mnw = 0;
      mon_en = 1'b0; tog = 1'b0; ready_level = 1'b1;
      rst_n = 1'b0; cfg_start = 1'b0; cfg_num_words = '0;
      in_valid = 1'b0; in_flg_act = '0; in_flg_wei = '0; out_ready = 1'b1;
      fork
         monitor();
         ready_driver();
      join_none

      // Reset state
      #3;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_addr_act", {20'd0, out_addr_act}, 32'd0);
      chk("rst_addr_wei", {20'd0, out_addr_wei}, 32'd0);
      chk("rst_match_cnt", {16'd0, match_cnt}, 32'd0);
      chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Basic two-word pass
      start_pass(2);
      send_word(32'h0000000F, 32'h0000000A);
      send_word(32'h00000001, 32'h00000001);
      wait_done(3);

      // Zero-match first word: accept then ADVANCE, back in FETCH two cycles later
      start_pass(2);
      send_word(32'h000000F0, 32'h0000000F);
      @(negedge clk);
      chk("zero_word_advance", {31'd0, in_ready}, 32'd0);
      chk("zero_word_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("zero_word_2cyc", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      send_word(32'h00000001, 32'h00000001);
      wait_done(1);

      // Empty pass
      start_pass(0);
      @(negedge clk);
      chk("empty_done", {31'd0, done}, 32'd1);
      chk("empty_busy", {31'd0, busy}, 32'd1);
      chk("empty_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("empty_done_drop", {31'd0, done}, 32'd0);
      chk("empty_busy_drop", {31'd0, busy}, 32'd0);
      chk("empty_match_cnt", {16'd0, match_cnt}, 32'd0);
      @(posedge clk); #1;

      // Backpressure: alternating out_ready
      tog = 1'b1;
      start_pass(1);
      send_word(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(32);
      tog = 1'b0;
      ready_level = 1'b1;
`ifdef FLG_MATCH_SCHED_STAT_EN
      chk("stall_cnt", {16'd0, stall_cnt}, 32'(tb_stall - stall_base));
`else
      chk("stall_cnt_off", {16'd0, stall_cnt}, 32'd0);
`endif
      @(posedge clk); #1;

      // Wrap (5-bit instance restarts at 0 each word) and ignored mid-pass cfg_start
      start_pass(3);
      send_word(32'hFFFFFFFF, 32'hFFFFFFFF);
      cfg_num_words = 16'd7;
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      send_word(32'hFFFFFFFF, 32'hFFFFFFFF);
      send_word(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(96);

      // Reset while a match is held under backpressure
      ready_level = 1'b0;
      start_pass(1);
      send_word(32'h000000FF, 32'h000000FF);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("valid_before_rst", {31'd0, ok}, 32'd1);
      #2;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_valid_w5", {31'd0, out_valid5}, 32'd0);
      chk("arst_addr_act", {20'd0, out_addr_act}, 32'd0);
      chk("arst_addr_wei", {20'd0, out_addr_wei}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_match_cnt", {16'd0, match_cnt}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_level = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      start_pass(1);
      send_word(32'h00000002, 32'h00000002);
      wait_done(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
